// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, one bit per clock, LSB first.
// Optional `SERIAL_ADD_OVF_EN adds a two's-complement overflow output (ovf_o).

module fulladder_rtl (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// state | meaning
// IDLE  | waiting for start, result held
// SHIFT | one operand bit added per edge
// DONE  | result valid (done pulse), may re-accept
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf_o,
`endif
    output logic             cout_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             fa_s, fa_co;
    logic             accept;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    fulladder_rtl u_fa (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_co)
    );

    assign accept = start_i && (state_q != SHIFT);

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE:  state_d = start_i ? SHIFT : IDLE;
            SHIFT: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                // New bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ fa_co;
`endif
                end
            end
            DONE:    state_d = start_i ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            a_sr_d  = a_i;
            b_sr_d  = b_i;
            carry_d = cin_i;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy_o = (state_q == SHIFT);
    assign done_o = (state_q == DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 instance plus a WIDTH=1 instance.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, start1 = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic       busy, done, cout, busy1, done1, cout1;
    logic [7:0] sum;
    logic [0:0] sum1;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf, ovf1;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .cin_i(cin),
        .busy_o(busy), .done_o(done), .sum_o(sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf_o(ovf),
`endif
        .cout_o(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .a_i(a1), .b_i(b1), .cin_i(cin1),
        .busy_o(busy1), .done_o(done1), .sum_o(sum1),
`ifdef SERIAL_ADD_OVF_EN
        .ovf_o(ovf1),
`endif
        .cout_o(cout1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a = av; b = bv; cin = cv; start = 1'b1;
        step();
        start = 1'b0;
        check("accept_busy", 64'(busy), 64'd1);
    endtask

    task automatic finish_op(input string tag, input logic [7:0] es, input logic ec, input logic eo);
        for (int i = 0; i < 7; i++) begin
            step();
            check({tag, "_busy_mid"}, 64'(busy), 64'd1);
            check({tag, "_done_mid"}, 64'(done), 64'd0);
        end
        step();
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADD_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) check({tag, "_ovf_arg"}, 64'(eo), 64'd0);
`endif
    endtask

    initial begin
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_w1_sum", 64'(sum1), 64'd0);
        step();
        rst = 1'b0;
        step();

        // 1: basic add, latency and hold
        accept_op(8'h3C, 8'h42, 1'b0);
        finish_op("t1", 8'h7E, 1'b0, 1'b0);
        step();
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_idle_busy", 64'(busy), 64'd0);
        check("t1_sum_held", 64'(sum), 64'h7E);

        // 2, 3: carry out and signed overflow
        accept_op(8'hFF, 8'h01, 1'b0);
        finish_op("t2", 8'h00, 1'b1, 1'b0);
        step();
        accept_op(8'h7F, 8'h00, 1'b1);
        finish_op("t3", 8'h80, 1'b0, 1'b1);
        step();

        // 4: start during SHIFT is ignored
        accept_op(8'h10, 8'h20, 1'b0);
        step();
        step();
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("t4_busy_ign", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) step();
        check("t4_busy_k7", 64'(busy), 64'd1);
        step();
        check("t4_done", 64'(done), 64'd1);
        check("t4_sum", 64'(sum), 64'h30);
        check("t4_cout", 64'(cout), 64'd0);
        step();
        check("t4_busy_fall", 64'(busy), 64'd0);

        // 5: asynchronous reset mid-operation
        accept_op(8'hAA, 8'h55, 1'b1);
        for (int i = 0; i < 4; i++) step();
        #2 rst = 1'b1;
        #1;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_sum", 64'(sum), 64'd0);
        check("t5_cout", 64'(cout), 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t5_no_done", 64'(done), 64'd0);
        end
        accept_op(8'h01, 8'h01, 1'b0);
        finish_op("t5b", 8'h02, 1'b0, 1'b0);
        step();

        // 6: back-to-back accept from DONE
        accept_op(8'h11, 8'h22, 1'b0);
        for (int i = 0; i < 7; i++) step();
        a = 8'h05; b = 8'h06; cin = 1'b0; start = 1'b1;
        step();
        check("t6_first_done", 64'(done), 64'd1);
        check("t6_first_sum", 64'(sum), 64'h33);
        step();
        start = 1'b0;
        check("t6_rebusy", 64'(busy), 64'd1);
        check("t6_redone", 64'(done), 64'd0);
        finish_op("t6", 8'h0B, 1'b0, 1'b0);
        step();

        // 7: WIDTH=1
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("t7_busy", 64'(busy1), 64'd1);
        check("t7_done_early", 64'(done1), 64'd0);
        step();
        check("t7_done", 64'(done1), 64'd1);
        check("t7_sum", 64'(sum1), 64'd1);
        check("t7_cout", 64'(cout1), 64'd1);
`ifdef SERIAL_ADD_OVF_EN
        check("t7_ovf", 64'(ovf1), 64'd0);
`endif
        step();
        check("t7_idle", 64'(done1), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
